// File: rtl/htif_tohost_poller.sv
// Round-robin tohost poller over the HTIF PCR request/reply port; clears tohost after each nonzero report.
// Optional cycle-limit watchdog with a max_cycles port: define HTIF_TIMEOUT_EN.
module htif_tohost_poller #(
    parameter int                NUM_CORES   = 1,
    parameter int                XLEN        = 32,
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 12'h780,
    parameter int                CORE_W      = 4,
    parameter int                POLL_GAP    = 4,
    parameter int                CYC_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_rw,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_data,
    output logic [CORE_W-1:0] req_core,
    input  logic              rep_valid,
    output logic              rep_ready,
    input  logic [XLEN-1:0]   rep_data,
    output logic              done,
    output logic              pass,
    output logic [XLEN-2:0]   exit_code,
    output logic [CORE_W-1:0] fail_core,
    output logic              timeout,
`ifdef HTIF_TIMEOUT_EN
    input  logic [CYC_W-1:0]  max_cycles,
`endif
    output logic [CYC_W-1:0]  cycle_cnt
);
    localparam int GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {IDLE, GAP, RD_REQ, RD_WAIT, CLR_REQ, CLR_WAIT, DONE} state_t;

    state_t               state;
    logic [CORE_W-1:0]    cur;
    logic [NUM_CORES-1:0] passed_mask;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 fail_flag;
    logic [CYC_W-1:0]     cnt_inc;

    // Next core after c (wrapping) whose bit in m is clear; c itself only if it is the sole candidate.
    function automatic logic [CORE_W-1:0] next_core(input logic [CORE_W-1:0] c,
                                                    input logic [NUM_CORES-1:0] m);
        logic [CORE_W-1:0] nc;
        nc = c;
        for (int k = NUM_CORES - 1; k >= 1; k--)
            for (int i = 0; i < NUM_CORES; i++)
                if (!m[i] && i == (int'(c) + k) % NUM_CORES) nc = CORE_W'(i);
        return nc;
    endfunction

    assign cnt_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CYC_W'(1);
    assign req_core = cur;
    assign req_data = '0;

`ifdef HTIF_TIMEOUT_EN
    logic timeout_r;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cur         <= '0;
            passed_mask <= '0;
            gap_cnt     <= '0;
            fail_flag   <= 1'b0;
            req_valid   <= 1'b0;
            req_rw      <= 1'b0;
            req_addr    <= '0;
            rep_ready   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            exit_code   <= '0;
            fail_core   <= '0;
            cycle_cnt   <= '0;
`ifdef HTIF_TIMEOUT_EN
            timeout_r   <= 1'b0;
`endif
        end else begin
            req_addr <= TOHOST_ADDR;
            if (state != DONE) cycle_cnt <= cnt_inc;
`ifdef HTIF_TIMEOUT_EN
            // Compare the count including this cycle so the frozen count is the one that tripped.
            if (state != DONE && max_cycles != '0 && cnt_inc > max_cycles) begin
                state     <= DONE;
                done      <= 1'b1;
                timeout_r <= 1'b1;
                pass      <= 1'b0;
                exit_code <= '0;
                fail_core <= cur;
                req_valid <= 1'b0;
                rep_ready <= 1'b0;
            end else
`endif
            begin
                case (state)
                    IDLE: if (enable) begin
                        state   <= GAP;
                        gap_cnt <= GAP_W'(POLL_GAP);
                    end
                    GAP: begin
                        if (!enable) state <= IDLE;
                        else if (gap_cnt == '0) begin
                            state     <= RD_REQ;
                            req_valid <= 1'b1;
                            req_rw    <= 1'b0;
                        end else gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                    RD_REQ, CLR_REQ: if (req_ready) begin
                        state     <= (state == RD_REQ) ? RD_WAIT : CLR_WAIT;
                        req_valid <= 1'b0;
                        rep_ready <= 1'b1;
                    end
                    RD_WAIT: if (rep_valid) begin
                        rep_ready <= 1'b0;
                        if (rep_data == '0) begin
                            cur     <= next_core(cur, passed_mask);
                            state   <= GAP;
                            gap_cnt <= GAP_W'(POLL_GAP);
                        end else begin
                            if (rep_data == XLEN'(1)) begin
                                for (int i = 0; i < NUM_CORES; i++)
                                    if (int'(cur) == i) passed_mask[i] <= 1'b1;
                            end else begin
                                exit_code <= rep_data[XLEN-1:1];
                                fail_core <= cur;
                                fail_flag <= 1'b1;
                            end
                            state     <= CLR_REQ;
                            req_valid <= 1'b1;
                            req_rw    <= 1'b1;
                        end
                    end
                    CLR_WAIT: if (rep_valid) begin
                        rep_ready <= 1'b0;
                        req_rw    <= 1'b0;
                        if (fail_flag || (&passed_mask)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= !fail_flag;
                        end else begin
                            cur     <= next_core(cur, passed_mask);
                            state   <= GAP;
                            gap_cnt <= GAP_W'(POLL_GAP);
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_htif_tohost_poller.sv
// Directed bench for htif_tohost_poller: one single-core and one three-core instance.
module tb_htif_tohost_poller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] enable = '0, req_ready = '0, rep_valid = '0;
    logic [1:0][31:0] rep_data = '0;
    logic [1:0][63:0] max_cycles = '0;
    wire  [1:0] req_valid, req_rw, rep_ready, done, pass, timeout;
    wire  [1:0][11:0] req_addr;
    wire  [1:0][31:0] req_data;
    wire  [1:0][3:0]  req_core, fail_core;
    wire  [1:0][30:0] exit_code;
    wire  [1:0][63:0] cycle_cnt;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    htif_tohost_poller #(.NUM_CORES(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]), .req_core(req_core[0]),
        .rep_valid(rep_valid[0]), .rep_ready(rep_ready[0]), .rep_data(rep_data[0]),
        .done(done[0]), .pass(pass[0]), .exit_code(exit_code[0]), .fail_core(fail_core[0]),
        .timeout(timeout[0]),
`ifdef HTIF_TIMEOUT_EN
        .max_cycles(max_cycles[0]),
`endif
        .cycle_cnt(cycle_cnt[0]));

    htif_tohost_poller #(.NUM_CORES(3)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]), .req_core(req_core[1]),
        .rep_valid(rep_valid[1]), .rep_ready(rep_ready[1]), .rep_data(rep_data[1]),
        .done(done[1]), .pass(pass[1]), .exit_code(exit_code[1]), .fail_core(fail_core[1]),
        .timeout(timeout[1]),
`ifdef HTIF_TIMEOUT_EN
        .max_cycles(max_cycles[1]),
`endif
        .cycle_cnt(cycle_cnt[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int s);
        return {7'd0, req_valid[s], req_rw[s], rep_ready[s], done[s], pass[s], timeout[s],
                req_core[s], fail_core[s], exit_code[s], req_addr[s]};
    endfunction

    task automatic do_reset();
        reset = 1'b0; enable = '0; req_ready = '0; rep_valid = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_outs", outs(s), 64'd0);
            chk("reset_cnt", cycle_cnt[s], 64'd0);
        end
        reset = 1'b1;
    endtask

    task automatic wait_req(input int s, output logic [3:0] core, output logic rw);
        int n = 0;
        while (req_valid[s] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        chk("req_seen", {63'd0, req_valid[s]}, 64'd1);
        chk("req_addr", {52'd0, req_addr[s]}, 64'h780);
        core = req_core[s];
        rw   = req_rw[s];
        if (rw) chk("wr_data", {32'd0, req_data[s]}, 64'd0);
    endtask

    task automatic handshake(input int s);
        req_ready[s] = 1'b1;
        @(negedge clk);
        req_ready[s] = 1'b0;
    endtask

    task automatic reply(input int s, input logic [31:0] d);
        chk("rep_ready", {63'd0, rep_ready[s]}, 64'd1);
        rep_valid[s] = 1'b1; rep_data[s] = d;
        @(negedge clk);
        rep_valid[s] = 1'b0;
    endtask

    task automatic poll(input int s, input logic [31:0] d, output logic [3:0] core, output logic rw);
        wait_req(s, core, rw);
        handshake(s);
        reply(s, d);
    endtask

    logic [3:0] c;
    logic rw;
    logic [3:0] rws;
    int exp_core[10] = '{0, 1, 1, 2, 0, 2, 0, 0, 2, 2};
    int exp_rw[10]   = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 1};
    int rdat[10]     = '{0, 1, 'hdead, 0, 0, 0, 1, 'hbeef, 1, 0};

    initial begin
        // 1: single core, 0,0,1 then clear
        do_reset();
        enable[0] = 1'b1;
        poll(0, 0, c, rws[0]);
        poll(0, 0, c, rws[1]);
        poll(0, 1, c, rws[2]);
        chk("t1_done_early", {63'd0, done[0]}, 64'd0);
        poll(0, 32'h1234, c, rws[3]);
        chk("t1_rw_seq", {60'd0, rws}, 64'b1000);
        chk("t1_done_pass", {62'd0, done[0], pass[0]}, 64'b11);
        chk("t1_timeout", {63'd0, timeout[0]}, 64'd0);
        repeat (3) @(negedge clk);
        chk("t1_sticky", {61'd0, done[0], pass[0], req_valid[0]}, 64'b110);

        // 2: failing report 0x2B
        do_reset();
        enable[0] = 1'b1;
        poll(0, 32'h2B, c, rw);
        poll(0, 0, c, rw);
        chk("t2_clear_rw", {63'd0, rw}, 64'd1);
        chk("t2_done_pass", {62'd0, done[0], pass[0]}, 64'b10);
        chk("t2_exit", {33'd0, exit_code[0]}, 64'd21);
        chk("t2_fail_core", {60'd0, fail_core[0]}, 64'd0);

        // 3: three cores, core 1 passes first and is skipped afterwards
        do_reset();
        enable[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk("t3_not_done", {63'd0, done[1]}, 64'd0);
            poll(1, 32'(rdat[i]), c, rw);
            chk($sformatf("t3_step%0d", i), {59'd0, c, rw}, 64'(exp_core[i] * 2 + exp_rw[i]));
        end
        chk("t3_done_pass", {62'd0, done[1], pass[1]}, 64'b11);

        // 4: back-pressure stability and a stray reply in GAP
        do_reset();
        enable[0] = 1'b1;
        wait_req(0, c, rw);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_stable", {47'd0, req_valid[0], req_addr[0], req_core[0]}, {47'd0, 1'b1, 12'h780, 4'd0});
        end
        handshake(0);
        reply(0, 0);
        rep_valid[0] = 1'b1; rep_data[0] = 32'd1;
        for (int i = 0; i < 2; i++) begin
            chk("t4_gap_rep_ready", {63'd0, rep_ready[0]}, 64'd0);
            @(negedge clk);
        end
        rep_valid[0] = 1'b0;
        poll(0, 1, c, rw);
        chk("t4_next_is_read", {63'd0, rw}, 64'd0);
        poll(0, 0, c, rw);
        chk("t4_done_pass", {62'd0, done[0], pass[0]}, 64'b11);

        // 6: reset while waiting for a read reply of core 1
        do_reset();
        enable[1] = 1'b1;
        poll(1, 0, c, rw);
        wait_req(1, c, rw);
        chk("t6_core1", {60'd0, c}, 64'd1);
        handshake(1);
        chk("t6_in_wait", {63'd0, rep_ready[1]}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_reset_outs", outs(1), 64'd0);
        chk("t6_reset_cnt", cycle_cnt[1], 64'd0);
        reset = 1'b1;
        wait_req(1, c, rw);
        chk("t6_first_core", {59'd0, c, rw}, 64'd0);

`ifdef HTIF_TIMEOUT_EN
        // 5: watchdog with max_cycles=50 and endless zero reports
        reset = 1'b0; enable = '0; req_ready = '0; rep_valid = '0;
        max_cycles[0] = 64'd50;
        repeat (2) @(negedge clk);
        reset = 1'b1; enable[0] = 1'b1; req_ready[0] = 1'b1; rep_data[0] = '0;
        for (int i = 0; i < 300 && !done[0]; i++) begin
            rep_valid[0] = rep_ready[0];
            @(negedge clk);
        end
        rep_valid[0] = 1'b0; req_ready[0] = 1'b0;
        chk("t5_flags", {61'd0, done[0], pass[0], timeout[0]}, 64'b101);
        chk("t5_cnt", cycle_cnt[0], 64'd51);
        chk("t5_exit", {33'd0, exit_code[0]}, 64'd0);
        repeat (5) @(negedge clk);
        chk("t5_frozen", cycle_cnt[0], 64'd51);
        max_cycles[0] = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
